plic_gateway_target: RTL and testbench

Interrupt gateway and target arbitration stage of the PLIC. It sits behind the PLIC register block and consumes that block's claim/complete requests, enable bits, priorities and thresholds. It synchronises raw peripheral interrupt lines, tracks a per-source pending/in-service state, and computes the winning claim ID and the external interrupt request for each target (hart context). It drives the pending vector and claim IDs back to the register block.

---
 rtl/plic_gateway_target.sv | 221 ++++++++++++++++++++++
 tb/tb_plic_gateway_target.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway_target.sv
// plic_gateway_target
// Interrupt gateway and per-target arbitration stage of the PLIC.
// Raw interrupt lines are synchronised and turned into level or edge triggers.
// Each source then runs an IDLE/PENDING/IN_SERVICE state machine, driven by
// the claim and complete requests from the register block.
// For every target, the highest-priority enabled pending source above the
// target threshold is presented as the claim ID. Ties go to the lowest ID.
//
// The regs2gateway_i bundle is a flat vector with the field layout of
// type_regs2gateway_s, MSB first: {claim_req[T], complete_req[T],
// complete_idx[T][SW]}.
module plic_gateway_target #(
    parameter int unsigned                  PLIC_SOURCE_COUNT = 2,
    parameter int unsigned                  PLIC_TARGET_COUNT = 2,
    parameter int unsigned                  PLIC_PRIO_WIDTH   = 3,
    parameter int unsigned                  PLIC_SOURCE_WIDTH = 2,
    parameter logic [PLIC_SOURCE_COUNT-1:0] PLIC_EDGE_MASK    = '0
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [PLIC_SOURCE_COUNT-1:0]                        irq_src_i,
    input  logic [PLIC_TARGET_COUNT*(PLIC_SOURCE_WIDTH+2)-1:0]  regs2gateway_i,
    input  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_COUNT-1:0] regs_ie_i,
    input  logic [PLIC_SOURCE_COUNT-1:0][PLIC_PRIO_WIDTH-1:0]   regs_prio_i,
    input  logic [PLIC_TARGET_COUNT-1:0][PLIC_PRIO_WIDTH-1:0]   regs_prio_th_i,
    output logic [PLIC_SOURCE_COUNT-1:0]                        irq_pending_o,
    output logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0] claim_idx_o,
    output logic [PLIC_TARGET_COUNT-1:0]                        irq_target_o
);

    localparam int unsigned S  = PLIC_SOURCE_COUNT;
    localparam int unsigned T  = PLIC_TARGET_COUNT;
    localparam int unsigned PW = PLIC_PRIO_WIDTH;
    localparam int unsigned SW = PLIC_SOURCE_WIDTH;

    typedef struct packed {
        logic [T-1:0]         claim_req;
        logic [T-1:0]         complete_req;
        logic [T-1:0][SW-1:0] complete_idx;
    } type_regs2gateway_s;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_e;

    type_regs2gateway_s        w_regs;

    logic [S-1:0]              r_sync1;
    logic [S-1:0]              r_sync2;
    logic [S-1:0]              r_prev;
    logic [S-1:0]              w_trigger;

    logic [T-1:0]              r_claim_req_q;
    logic [T-1:0]              w_claim_evt;

    state_e                    r_state     [S];
    state_e                    w_state_nxt [S];
    logic [S-1:0]              r_edge_flag;
    logic [S-1:0]              w_edge_flag_nxt;

    logic [S-1:0]              w_claimed;
    logic [S-1:0]              w_completed;

    logic [T-1:0][S-1:0]       w_eligible;
    logic [T-1:0][PW-1:0]      w_best_prio;
    logic [T-1:0][SW-1:0]      w_claim_idx;
    logic [T-1:0]              r_irq_target;

    assign w_regs = type_regs2gateway_s'(regs2gateway_i);

    // Two-flop synchroniser for the raw lines, plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= irq_src_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_trigger = (r_sync2 & ~r_prev & PLIC_EDGE_MASK)
                     | (r_sync2 & ~PLIC_EDGE_MASK);

    // Remember the previous claim request so that a held request claims only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_claim_req_q <= '0;
        end else begin
            r_claim_req_q <= w_regs.claim_req;
        end
    end

    assign w_claim_evt = w_regs.claim_req & ~r_claim_req_q;

    // Decode which sources are claimed or completed this cycle by any target.
    always_comb begin
        w_claimed   = '0;
        w_completed = '0;
        for (int unsigned s = 0; s < S; s++) begin
            for (int unsigned t = 0; t < T; t++) begin
                if (w_claim_evt[t] && (w_claim_idx[t] == SW'(s + 1))) begin
                    w_claimed[s] = 1'b1;
                end
                if (w_regs.complete_req[t] && (w_regs.complete_idx[t] == SW'(s + 1))) begin
                    w_completed[s] = 1'b1;
                end
            end
        end
    end

    // Per-source state register and one-deep edge memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < S; s++) begin
                r_state[s] <= ST_IDLE;
            end
            r_edge_flag <= '0;
        end else begin
            for (int unsigned s = 0; s < S; s++) begin
                r_state[s] <= w_state_nxt[s];
            end
            r_edge_flag <= w_edge_flag_nxt;
        end
    end

    // Per-source next-state logic. A completion that re-pends from the
    // edge flag consumes the flag. An edge arriving in that same cycle
    // stays remembered.
    always_comb begin
        w_state_nxt     = r_state;
        w_edge_flag_nxt = r_edge_flag;
        for (int unsigned s = 0; s < S; s++) begin
            case (r_state[s])
                ST_IDLE: begin
                    if (w_trigger[s]) begin
                        w_state_nxt[s] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_claimed[s]) begin
                        w_state_nxt[s] = ST_IN_SERVICE;
                    end
                    if (PLIC_EDGE_MASK[s] && w_trigger[s]) begin
                        w_edge_flag_nxt[s] = 1'b1;
                    end
                end
                ST_IN_SERVICE: begin
                    if (w_completed[s]) begin
                        if (r_edge_flag[s] || (PLIC_EDGE_MASK[s] && w_trigger[s])) begin
                            w_state_nxt[s] = ST_PENDING;
                        end else begin
                            w_state_nxt[s] = ST_IDLE;
                        end
                        w_edge_flag_nxt[s] = r_edge_flag[s] & w_trigger[s];
                    end else if (PLIC_EDGE_MASK[s] && w_trigger[s]) begin
                        w_edge_flag_nxt[s] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[s]     = ST_IDLE;
                    w_edge_flag_nxt[s] = 1'b0;
                end
            endcase
        end
    end

    // Pending vector reported back to the register block.
    always_comb begin
        irq_pending_o = '0;
        for (int unsigned s = 0; s < S; s++) begin
            irq_pending_o[s] = (r_state[s] == ST_PENDING);
        end
    end

    // Eligibility: pending, enabled for the target and strictly above its threshold.
    always_comb begin
        w_eligible = '0;
        for (int unsigned t = 0; t < T; t++) begin
            for (int unsigned s = 0; s < S; s++) begin
                w_eligible[t][s] = (r_state[s] == ST_PENDING) && regs_ie_i[t][s]
                                 && (regs_prio_i[s] > regs_prio_th_i[t]);
            end
        end
    end

    // Winner selection: ascending scan with a strict compare keeps the lowest ID on ties.
    always_comb begin
        w_claim_idx = '0;
        w_best_prio = '0;
        for (int unsigned t = 0; t < T; t++) begin
            for (int unsigned s = 0; s < S; s++) begin
                if (w_eligible[t][s]
                    && ((w_claim_idx[t] == '0) || (regs_prio_i[s] > w_best_prio[t]))) begin
                    w_claim_idx[t] = SW'(s + 1);
                    w_best_prio[t] = regs_prio_i[s];
                end
            end
        end
    end

    assign claim_idx_o = w_claim_idx;

    // Registered interrupt request towards each hart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_target <= '0;
        end else begin
            for (int unsigned t = 0; t < T; t++) begin
                r_irq_target[t] <= (w_claim_idx[t] != '0);
            end
        end
    end

    assign irq_target_o = r_irq_target;

endmodule

// File: tb/tb_plic_gateway_target.sv
// tb_plic_gateway_target
// Randomised and directed stimulus for plic_gateway_target.
// All outputs are compared every cycle against a behavioural reference model.
// Source 0 is edge triggered and source 1 is level triggered.
module tb_plic_gateway_target;

    localparam int S  = 2;
    localparam int T  = 2;
    localparam int PW = 3;
    localparam int SW = 2;
    localparam logic [S-1:0] EDGE = 2'b01;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [S-1:0]          irq_src;
    logic [T-1:0]          claim_req;
    logic [T-1:0]          complete_req;
    logic [T-1:0][SW-1:0]  complete_idx;
    logic [T-1:0][S-1:0]   ie;
    logic [S-1:0][PW-1:0]  prio;
    logic [T-1:0][PW-1:0]  th;
    logic [T*(SW+2)-1:0]   regs2gw;

    logic [S-1:0]          irq_pending_o;
    logic [T-1:0][SW-1:0]  claim_idx_o;
    logic [T-1:0]          irq_target_o;

    assign regs2gw = {claim_req, complete_req, complete_idx};

    plic_gateway_target #(
        .PLIC_SOURCE_COUNT (S),
        .PLIC_TARGET_COUNT (T),
        .PLIC_PRIO_WIDTH   (PW),
        .PLIC_SOURCE_WIDTH (SW),
        .PLIC_EDGE_MASK    (EDGE)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src_i      (irq_src),
        .regs2gateway_i (regs2gw),
        .regs_ie_i      (ie),
        .regs_prio_i    (prio),
        .regs_prio_th_i (th),
        .irq_pending_o  (irq_pending_o),
        .claim_idx_o    (claim_idx_o),
        .irq_target_o   (irq_target_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state.
    // Line samples per source: index 0 is the newest sample.
    bit           m_samp   [S][3];
    bit           m_pend   [S];
    bit           m_insvc  [S];
    bit           m_credit [S];
    bit [T-1:0]   m_claim_last;
    bit [T-1:0]   m_target;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner(input int t);
        int best = 0;
        int best_p = -1;
        for (int s = 0; s < S; s++) begin
            if (m_pend[s] && ie[t][s] && (prio[s] > th[t]) && (int'(prio[s]) > best_p)) begin
                best   = s + 1;
                best_p = int'(prio[s]);
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            for (int k = 0; k < 3; k++) m_samp[s][k] = 1'b0;
            m_pend[s]   = 1'b0;
            m_insvc[s]  = 1'b0;
            m_credit[s] = 1'b0;
        end
        m_claim_last = '0;
        m_target     = '0;
    endtask

    // Advance the model across one rising clock edge using the current inputs.
    task automatic model_clock();
        int  win [T];
        bit  trig, claimed, completed, is_edge;
        for (int t = 0; t < T; t++) win[t] = model_winner(t);
        for (int s = 0; s < S; s++) begin
            is_edge   = EDGE[s];
            trig      = is_edge ? (m_samp[s][1] && !m_samp[s][2]) : m_samp[s][1];
            claimed   = 1'b0;
            completed = 1'b0;
            for (int t = 0; t < T; t++) begin
                if (claim_req[t] && !m_claim_last[t] && win[t] == s + 1) claimed = 1'b1;
                if (complete_req[t] && int'(complete_idx[t]) == s + 1) completed = 1'b1;
            end
            if (m_insvc[s]) begin
                if (completed) begin
                    m_insvc[s] = 1'b0;
                    if (m_credit[s] || (is_edge && trig)) m_pend[s] = 1'b1;
                    m_credit[s] = m_credit[s] && trig;
                end else if (is_edge && trig) begin
                    m_credit[s] = 1'b1;
                end
            end else if (m_pend[s]) begin
                if (is_edge && trig) m_credit[s] = 1'b1;
                if (claimed) begin
                    m_pend[s]  = 1'b0;
                    m_insvc[s] = 1'b1;
                end
            end else if (trig) begin
                m_pend[s] = 1'b1;
            end
        end
        for (int t = 0; t < T; t++) m_target[t] = (win[t] != 0);
        m_claim_last = claim_req;
        for (int s = 0; s < S; s++) begin
            m_samp[s][2] = m_samp[s][1];
            m_samp[s][1] = m_samp[s][0];
            m_samp[s][0] = irq_src[s];
        end
    endtask

    task automatic check_outputs();
        logic [S-1:0] exp_pend;
        for (int s = 0; s < S; s++) exp_pend[s] = m_pend[s];
        check_eq("pending", 32'(irq_pending_o), 32'(exp_pend));
        for (int t = 0; t < T; t++) begin
            check_eq($sformatf("claim_idx[%0d]", t), 32'(claim_idx_o[t]), 32'(model_winner(t)));
        end
        check_eq("irq_target", 32'(irq_target_o), 32'(m_target));
    endtask

    // Called 1 time unit after a rising edge. It checks the outputs, then crosses the next edge.
    task automatic step();
        #3;
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic claim_pulse(input logic [T-1:0] mask);
        claim_req = mask;
        step();
        step();
        claim_req = '0;
        step();
    endtask

    task automatic do_complete(input int t, input int id);
        complete_req[t] = 1'b1;
        complete_idx[t] = SW'(id);
        step();
        complete_req = '0;
        complete_idx = '0;
    endtask

    task automatic edge_pulse(input int s);
        irq_src[s] = 1'b1;
        step();
        step();
        irq_src[s] = 1'b0;
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        irq_src      = '0;
        claim_req    = '0;
        complete_req = '0;
        complete_idx = '0;
        ie           = '0;
        prio         = '0;
        th           = '0;
        model_reset();
        #2;
        check_eq("rst_pending", 32'(irq_pending_o), 32'd0);
        check_eq("rst_claim", 32'(claim_idx_o), 32'd0);
        check_eq("rst_target", 32'(irq_target_o), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        model_clock();
        #1;

        // Level source (ID 2): latency, held claim, completion.
        prio[1] = 3'd3;
        th[0]   = 3'd1;
        th[1]   = 3'd7;
        ie[0]   = 2'b10;
        irq_src[1] = 1'b1;
        step();
        step();
        #1 check_eq("lvl_pend_early", 32'(irq_pending_o), 32'd0);
        step();
        #1 check_eq("lvl_pend_lat", 32'(irq_pending_o), 32'b10);
        check_eq("lvl_claim_lat", 32'(claim_idx_o[0]), 32'd2);
        check_eq("lvl_target_early", 32'(irq_target_o[0]), 32'd0);
        step();
        #1 check_eq("lvl_target_lat", 32'(irq_target_o[0]), 32'd1);
        claim_pulse(2'b01);
        step();
        #1 check_eq("lvl_claimed_pend", 32'(irq_pending_o), 32'd0);
        check_eq("lvl_claimed_target", 32'(irq_target_o[0]), 32'd0);
        irq_src[1] = 1'b0;
        step();
        step();
        step();
        do_complete(0, 2);
        step();
        step();

        // Arbitration: tie, priority change, threshold change.
        ie[0]   = 2'b11;
        prio[0] = 3'd2;
        prio[1] = 3'd2;
        th[0]   = 3'd1;
        irq_src = 2'b11;
        for (int i = 0; i < 4; i++) step();
        #1 check_eq("arb_tie", 32'(claim_idx_o[0]), 32'd1);
        prio[1] = 3'd5;
        #1 check_eq("arb_prio", 32'(claim_idx_o[0]), 32'd2);
        step();
        th[0] = 3'd5;
        #1 check_eq("arb_th", 32'(claim_idx_o[0]), 32'd0);
        step();
        #1 check_eq("arb_th_target", 32'(irq_target_o[0]), 32'd0);
        th[0] = 3'd0;
        step();

        // Level re-pend: complete while the line is still high.
        claim_pulse(2'b01);
        do_complete(0, 2);
        #1 check_eq("lvl_repend_gap", 32'(irq_pending_o[1]), 32'd0);
        step();
        #1 check_eq("lvl_repend", 32'(irq_pending_o[1]), 32'd1);
        irq_src = '0;
        step();
        step();
        step();
        claim_pulse(2'b01);
        do_complete(0, 2);
        claim_pulse(2'b01);
        do_complete(0, 1);
        step();
        step();

        // Edge source (ID 1): three edges while in service collapse to one.
        ie[0]   = 2'b01;
        prio[0] = 3'd3;
        th[0]   = 3'd0;
        edge_pulse(0);
        step();
        claim_pulse(2'b01);
        edge_pulse(0);
        edge_pulse(0);
        edge_pulse(0);
        step();
        step();
        do_complete(0, 1);
        #1 check_eq("edge_repend", 32'(irq_pending_o[0]), 32'd1);
        claim_pulse(2'b01);
        step();
        step();
        do_complete(0, 1);
        step();
        #1 check_eq("edge_idle", 32'(irq_pending_o[0]), 32'd0);

        // Two targets claim the same ID in the same cycle.
        ie[0] = 2'b01;
        ie[1] = 2'b01;
        th    = '0;
        edge_pulse(0);
        step();
        #1 check_eq("two_tgt_claim0", 32'(claim_idx_o[0]), 32'd1);
        check_eq("two_tgt_claim1", 32'(claim_idx_o[1]), 32'd1);
        claim_req = 2'b11;
        step();
        claim_req = '0;
        step();
        #1 check_eq("two_tgt_insvc", 32'(irq_pending_o[0]), 32'd0);
        do_complete(1, 1);
        do_complete(0, 2);
        do_complete(0, 0);
        do_complete(1, 3);
        step();
        step();

        // Asynchronous reset while a level source is in service.
        ie[0]      = 2'b10;
        ie[1]      = 2'b00;
        prio[1]    = 3'd4;
        irq_src[1] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        claim_pulse(2'b01);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_pending", 32'(irq_pending_o), 32'd0);
        check_eq("async_rst_claim", 32'(claim_idx_o), 32'd0);
        check_eq("async_rst_target", 32'(irq_target_o), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        step();
        #1 check_eq("rst_repend_early", 32'(irq_pending_o[1]), 32'd0);
        step();
        #1 check_eq("rst_repend", 32'(irq_pending_o[1]), 32'd1);
        step();

        // Randomised traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < S; s++) begin
                if ($urandom_range(0, 7) == 0) irq_src[s] = ~irq_src[s];
            end
            for (int t = 0; t < T; t++) begin
                claim_req[t]    = ($urandom_range(0, 3) == 0);
                complete_req[t] = ($urandom_range(0, 3) == 0);
                complete_idx[t] = SW'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 31) == 0) begin
                for (int s = 0; s < S; s++) prio[s] = PW'($urandom_range(0, 7));
                for (int t = 0; t < T; t++) begin
                    th[t] = PW'($urandom_range(0, 3));
                    ie[t] = S'($urandom_range(0, 3));
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
